// File: rtl/vector_mem_port.sv
// vector_mem_port: runs one data-bus transaction per address-unit beat.
// Loads compact the enabled response bytes into dense VRF words.
// Stores forward lane-aligned data with the beat's byte enables.
// Optional bus-error reporting is compiled in with VECTOR_MEM_PORT_ERR_EN.
module vector_mem_port #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [4:0]        vl_i,
    input  logic [1:0]        vsew_i,
    input  logic [ADDR_W-1:0] au_addr_i,
    input  logic [3:0]        au_be_i,
    input  logic              au_valid_i,
    output logic              au_next_o,
    input  logic [31:0]       st_wdata_i,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    output logic              ld_valid_o,
    output logic [IDX_W-1:0]  ld_idx_o,
    output logic [31:0]       ld_data_o,
    output logic [3:0]        ld_be_o,
    output logic              busy_o,
    output logic              done_o
`ifdef VECTOR_MEM_PORT_ERR_EN
    ,
    input  logic              data_err_i,
    output logic              err_o
`endif
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_AU, S_REQ, S_RESP, S_NEXT, S_FLUSH, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic                r_we;
    logic [6:0]          r_rem;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [63:0]         r_buf;
    logic [1:0]          r_cnt;
    logic [IDX_W-1:0]    r_widx;
    logic                r_ld_valid;
    logic [IDX_W-1:0]    r_ld_idx;
    logic [31:0]         r_ld_data;
    logic [3:0]          r_ld_be;

    logic [6:0]          w_rem_init;
    logic [2:0]          w_pop;
    logic [6:0]          w_rem_sub;
    logic [31:0]         w_comp;
    logic [1:0]          w_slot;
    logic [63:0]         w_buf;
    logic [2:0]          w_sum;
    logic [3:0]          w_fmask;
    logic                w_err_now;
    logic                w_err_q;

    assign w_rem_init = {2'b00, vl_i} << vsew_i;
    assign w_pop      = 3'($countones(r_be));
    assign w_rem_sub  = (r_rem > {4'b0, w_pop}) ? (r_rem - {4'b0, w_pop}) : 7'd0;
    // cnt stays below 4 between beats, so the low two sum bits are the new count
    assign w_sum      = {1'b0, r_cnt} + w_pop;
    assign w_buf      = r_buf | ({32'b0, w_comp} << {r_cnt, 3'b000});
    assign w_fmask    = (r_cnt == 2'd1) ? 4'b0001 : (r_cnt == 2'd2) ? 4'b0011 : 4'b0111;

    assign data_addr_o  = r_addr;
    assign data_be_o    = r_be;
    assign data_we_o    = r_we;
    assign data_wdata_o = r_wdata;
    assign ld_valid_o   = r_ld_valid;
    assign ld_idx_o     = r_ld_idx;
    assign ld_data_o    = r_ld_data;
    assign ld_be_o      = r_ld_be;

    // Gather the enabled response lanes into the low bytes in ascending order
    always_comb begin
        w_comp = '0;
        w_slot = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_comp[{w_slot, 3'b000} +: 8] = data_rdata_i[i*8 +: 8];
                w_slot = w_slot + 2'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        data_req_o = 1'b0;
        au_next_o  = 1'b0;
        done_o     = 1'b0;
        busy_o     = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = (w_rem_init == 7'd0) ? S_DONE : S_WAIT_AU;
            end
            S_WAIT_AU: if (au_valid_i) w_next = S_REQ;
            S_REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) w_next = S_RESP;
            end
            S_RESP: begin
                if (data_rvalid_i) begin
                    if (w_rem_sub != 7'd0) w_next = S_NEXT;
                    else                   w_next = r_we ? S_DONE : S_FLUSH;
                end
            end
            S_NEXT: begin
                au_next_o = 1'b1;
                w_next    = S_WAIT_AU;
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Beat capture, byte accounting, load packer and registered VRF write port
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_we       <= 1'b0;
            r_rem      <= '0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_widx     <= '0;
            r_ld_valid <= 1'b0;
            r_ld_idx   <= '0;
            r_ld_data  <= '0;
            r_ld_be    <= '0;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_we   <= we_i;
                    r_rem  <= w_rem_init;
                    r_buf  <= '0;
                    r_cnt  <= '0;
                    r_widx <= '0;
                end
                S_WAIT_AU: if (au_valid_i) begin
                    r_addr  <= au_addr_i;
                    r_be    <= au_be_i;
                    r_wdata <= st_wdata_i;
                end
                S_RESP: if (data_rvalid_i) begin
                    r_rem <= w_rem_sub;
                    if (!r_we) begin
                        r_cnt <= w_sum[1:0];
                        if (w_sum[2]) begin
                            // packer keeps draining after an error; only the write is dropped
                            if (!w_err_now) begin
                                r_ld_valid <= 1'b1;
                                r_ld_idx   <= r_widx;
                                r_ld_data  <= w_buf[31:0];
                                r_ld_be    <= 4'b1111;
                            end
                            r_buf  <= {32'b0, w_buf[63:32]};
                            r_widx <= r_widx + 1'b1;
                        end else begin
                            r_buf <= w_buf;
                        end
                    end
                end
                S_FLUSH: if (r_cnt != 2'd0 && !w_err_q) begin
                    r_ld_valid <= 1'b1;
                    r_ld_idx   <= r_widx;
                    r_ld_data  <= r_buf[31:0];
                    r_ld_be    <= w_fmask;
                end
                default: ;
            endcase
        end
    end

`ifdef VECTOR_MEM_PORT_ERR_EN
    logic r_err;

    assign w_err_now = r_err | data_err_i;
    assign w_err_q   = r_err;
    assign err_o     = (r_state == S_DONE) & r_err;

    // Sticky bus-error flag, cleared by the next accepted start
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)                                        r_err <= 1'b0;
        else if (r_state == S_IDLE && start_i)               r_err <= 1'b0;
        else if (r_state == S_RESP && data_rvalid_i && data_err_i) r_err <= 1'b1;
    end
`else
    assign w_err_now = 1'b0;
    assign w_err_q   = 1'b0;
`endif

endmodule

// File: tb/tb_vector_mem_port.sv
// Scoreboard bench for vector_mem_port: directed test-plan cases plus random
// operations against a byte-stream reference model. Error cases are compiled
// in only when VECTOR_MEM_PORT_ERR_EN is defined.
module tb_vector_mem_port;
    logic        clk_i = 1'b0;
    logic        n_rst_i = 1'b0;
    logic        start_i, we_i, au_valid_i, au_next_o;
    logic [4:0]  vl_i;
    logic [1:0]  vsew_i;
    logic [31:0] au_addr_i, st_wdata_i;
    logic [3:0]  au_be_i;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        ld_valid_o, busy_o, done_o;
    logic [4:0]  ld_idx_o;
    logic [31:0] ld_data_o;
    logic [3:0]  ld_be_o;
`ifdef VECTOR_MEM_PORT_ERR_EN
    logic        data_err_i, err_o;
`endif

    vector_mem_port #(.ADDR_W(32), .IDX_W(5)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .start_i(start_i), .we_i(we_i),
        .vl_i(vl_i), .vsew_i(vsew_i), .au_addr_i(au_addr_i), .au_be_i(au_be_i),
        .au_valid_i(au_valid_i), .au_next_o(au_next_o), .st_wdata_i(st_wdata_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .ld_valid_o(ld_valid_o), .ld_idx_o(ld_idx_o), .ld_data_o(ld_data_o),
        .ld_be_o(ld_be_o), .busy_o(busy_o), .done_o(done_o)
`ifdef VECTOR_MEM_PORT_ERR_EN
        , .data_err_i(data_err_i), .err_o(err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } beat_t;
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic [3:0]  be;
    } ldw_t;

    beat_t cur[$];
    beat_t bus_q[$];
    ldw_t  exp_ld[$];
    logic  exp_done[$];
    int    total = 0;
    int    bad = 0;
    int    next_cnt = 0;
    bit    bus_auto = 1'b1;
    int    min_stall = 0;
    int    max_stall = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    // VRF write and completion monitor
    always @(negedge clk_i) begin
        ldw_t e;
        logic ee;
        if (au_next_o) next_cnt++;
        if (ld_valid_o) begin
            if (exp_ld.size() == 0) chk("ld_unexpected", 1, 0);
            else begin
                e = exp_ld.pop_front();
                chk("ld_idx", ld_idx_o, e.idx);
                chk("ld_be", ld_be_o, e.be);
                chk("ld_data", ld_data_o & bmask(e.be), e.data & bmask(e.be));
            end
        end
        if (done_o) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                ee = exp_done.pop_front();
                chk("done_busy", busy_o, 1);
`ifdef VECTOR_MEM_PORT_ERR_EN
                chk("done_err", err_o, ee);
`endif
            end
        end
    end

    // Bus slave: optional grant stall, request checks, delayed response
    initial begin
        beat_t b;
        int d;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
`ifdef VECTOR_MEM_PORT_ERR_EN
        data_err_i = 0;
`endif
        forever begin
            @(negedge clk_i);
            if (bus_auto && n_rst_i && data_req_o) begin
                if (bus_q.size() == 0) chk("req_unexpected", 1, 0);
                else begin
                    b = bus_q[0];
                    d = $urandom_range(min_stall, max_stall);
                    repeat (d) begin
                        chk("stall_req", data_req_o, 1);
                        chk("stall_addr", data_addr_o, b.addr);
                        chk("stall_be", data_be_o, b.be);
                        chk("stall_next", au_next_o, 0);
                        @(negedge clk_i);
                    end
                    chk("req_addr", data_addr_o, b.addr);
                    chk("req_be", data_be_o, b.be);
                    chk("req_we", data_we_o, b.we);
                    if (b.we) chk("req_wdata", data_wdata_o & bmask(b.be), b.wdata & bmask(b.be));
                    data_gnt_i = 1;
                    @(negedge clk_i);
                    data_gnt_i = 0;
                    chk("req_drop", data_req_o, 0);
                    void'(bus_q.pop_front());
                    repeat ($urandom_range(0, 2)) @(negedge clk_i);
                    data_rvalid_i = 1; data_rdata_i = b.rdata;
`ifdef VECTOR_MEM_PORT_ERR_EN
                    data_err_i = b.err;
`endif
                    @(negedge clk_i);
                    data_rvalid_i = 0; data_rdata_i = $urandom;
`ifdef VECTOR_MEM_PORT_ERR_EN
                    data_err_i = 0;
`endif
                end
            end
        end
    end

    task automatic add_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                            input logic [31:0] rd, input logic er, input logic we);
        beat_t b;
        b.addr = a; b.be = be; b.wdata = wd; b.rdata = rd; b.err = er; b.we = we;
        cur.push_back(b);
    endtask

    // Random beats until the enabled-byte total covers vl<<vsew
    task automatic gen_beats(input logic we, input logic [1:0] vsew, input logic [4:0] vl);
        int need, acc;
        logic [3:0] be;
        cur.delete();
        need = int'(vl) << vsew;
        acc = 0;
        while (acc < need) begin
            be = 4'($urandom_range(1, 15));
`ifdef VECTOR_MEM_PORT_ERR_EN
            add_beat($urandom & 32'hFFFF_FFFC, be, $urandom, $urandom, ($urandom_range(0, 19) == 0), we);
`else
            add_beat($urandom & 32'hFFFF_FFFC, be, $urandom, $urandom, 1'b0, we);
`endif
            acc += $countones(be);
        end
    endtask

    // Expected behaviour: enabled bytes form one dense stream cut into words
    task automatic run_op(input logic we, input logic [1:0] vsew, input logic [4:0] vl, input bit poke);
        logic [7:0] bq[$];
        int errbeat, k, t, cut;
        bit ok;
        ldw_t w;
        errbeat = -1;
        foreach (cur[i]) if (cur[i].err && errbeat < 0) errbeat = i;
        if (!we) begin
            cut = (errbeat < 0) ? cur.size() : errbeat;
            for (int i = 0; i < cut; i++)
                for (int j = 0; j < 4; j++)
                    if (cur[i].be[j]) bq.push_back(cur[i].rdata[j*8 +: 8]);
            k = 0;
            while (bq.size() >= 4) begin
                w.idx = 5'(k); w.be = 4'b1111;
                w.data = {bq[3], bq[2], bq[1], bq[0]};
                repeat (4) void'(bq.pop_front());
                exp_ld.push_back(w); k++;
            end
            if (errbeat < 0 && bq.size() > 0) begin
                w.idx = 5'(k); w.be = 4'((1 << bq.size()) - 1); w.data = 0;
                foreach (bq[j]) w.data[j*8 +: 8] = bq[j];
                exp_ld.push_back(w);
            end
        end
        exp_done.push_back(errbeat >= 0);
        next_cnt = 0;
        ok = 1;
        @(negedge clk_i);
        start_i = 1; we_i = we; vl_i = vl; vsew_i = vsew;
        @(negedge clk_i);
        start_i = 0; we_i = $urandom; vl_i = $urandom;
        chk("busy_start", busy_o, 1);
        foreach (cur[i]) begin
            if (!ok) break;
            au_addr_i = cur[i].addr; au_be_i = cur[i].be; st_wdata_i = cur[i].wdata;
            au_valid_i = 1;
            bus_q.push_back(cur[i]);
            @(negedge clk_i);
            au_valid_i = 0; au_addr_i = $urandom; au_be_i = $urandom; st_wdata_i = $urandom;
            if (poke && i == 0) begin
                start_i = 1; vl_i = 0;
                @(negedge clk_i);
                start_i = 0;
            end
            if (i != cur.size() - 1) begin
                t = 0;
                while (!au_next_o && t < 200) begin @(negedge clk_i); t++; end
                if (t >= 200) begin chk("au_next_timeout", 0, 1); ok = 0; end
                else repeat (1 + $urandom_range(0, 2)) @(negedge clk_i);
            end
        end
        t = 0;
        while (busy_o && t < 300) begin @(negedge clk_i); t++; end
        if (t >= 300) chk("busy_timeout", 0, 1);
        @(negedge clk_i);
        chk("au_next_count", next_cnt, (cur.size() > 0) ? cur.size() - 1 : 0);
        chk("ld_missing", exp_ld.size(), 0);
        chk("done_missing", exp_done.size(), 0);
        chk("bus_leftover", bus_q.size(), 0);
        exp_ld.delete(); exp_done.delete(); bus_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start_i = 0; we_i = 0; vl_i = 0; vsew_i = 0;
        au_addr_i = 0; au_be_i = 0; au_valid_i = 0; st_wdata_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", data_req_o, 0);
        chk("rst_ld_valid", ld_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_next", au_next_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_ld_be", ld_be_o, 0);
        n_rst_i = 1;

        // three full 32-bit beats, no partial word
        cur.delete();
        add_beat(32'h100, 4'hF, 0, 32'hAABBCCDD, 0, 0);
        add_beat(32'h104, 4'hF, 0, 32'h11223344, 0, 0);
        add_beat(32'h108, 4'hF, 0, 32'h55667788, 0, 0);
        run_op(0, 2'd2, 5'd3, 0);

        // byte elements scattered across lanes, partial flush
        cur.delete();
        add_beat(32'h100, 4'b0010, 0, 32'h0000EE00, 0, 0);
        add_beat(32'h104, 4'b1001, 0, 32'h13000010, 0, 0);
        add_beat(32'h108, 4'b0100, 0, 32'h00220000, 0, 0);
        add_beat(32'h10C, 4'b0001, 0, 32'h00000033, 0, 0);
        run_op(0, 2'd0, 5'd5, 0);

        // five-cycle grant stall
        min_stall = 5; max_stall = 5;
        cur.delete();
        add_beat(32'h240, 4'b0011, 0, 32'hCAFEF00D, 0, 0);
        run_op(0, 2'd1, 5'd1, 0);
        min_stall = 0; max_stall = 0;

        // store, with a start pulse that must be ignored mid-operation
        cur.delete();
        add_beat(32'h300, 4'hF, 32'h12345678, 32'hDEADBEEF, 0, 1);
        run_op(1, 2'd1, 5'd2, 1);

        // zero-length operation completes without bus traffic
        cur.delete();
        run_op(0, 2'd2, 5'd0, 0);

        // reset while waiting for the response
        bus_auto = 0;
        @(negedge clk_i);
        start_i = 1; we_i = 0; vl_i = 2; vsew_i = 2;
        @(negedge clk_i);
        start_i = 0; au_valid_i = 1; au_addr_i = 32'h200; au_be_i = 4'hF;
        @(negedge clk_i);
        au_valid_i = 0;
        chk("rrst_req_pre", data_req_o, 1);
        data_gnt_i = 1;
        @(negedge clk_i);
        data_gnt_i = 0;
        n_rst_i = 0;
        #1;
        chk("rrst_busy", busy_o, 0);
        chk("rrst_req", data_req_o, 0);
        chk("rrst_addr", data_addr_o, 0);
        chk("rrst_next", au_next_o, 0);
        chk("rrst_done", done_o, 0);
        @(negedge clk_i);
        n_rst_i = 1; data_rvalid_i = 1; data_rdata_i = 32'h01020304;
        @(negedge clk_i);
        data_rvalid_i = 0;
        au_valid_i = 1; au_addr_i = 32'h400; au_be_i = 4'hF;
        @(negedge clk_i);
        au_valid_i = 0;
        repeat (3) begin
            chk("rrst_idle_busy", busy_o, 0);
            chk("rrst_idle_req", data_req_o, 0);
            @(negedge clk_i);
        end
        bus_auto = 1;

        cur.delete();
        add_beat(32'h500, 4'hF, 0, 32'h0BADC0DE, 0, 0);
        add_beat(32'h504, 4'b0110, 0, 32'h00ABCD00, 0, 0);
        run_op(0, 2'd1, 5'd3, 0);

`ifdef VECTOR_MEM_PORT_ERR_EN
        // error on the middle beat, then a clean operation
        cur.delete();
        add_beat(32'h100, 4'hF, 0, 32'hAABBCCDD, 0, 0);
        add_beat(32'h104, 4'hF, 0, 32'h11223344, 1, 0);
        add_beat(32'h108, 4'hF, 0, 32'h55667788, 0, 0);
        run_op(0, 2'd2, 5'd3, 0);
        cur.delete();
        add_beat(32'h100, 4'hF, 0, 32'h99887766, 0, 0);
        run_op(0, 2'd2, 5'd1, 0);
`endif

        // random operations
        max_stall = 3;
        for (int n = 0; n < 25; n++) begin
            logic rwe;
            logic [1:0] rsew;
            logic [4:0] rvl;
            rwe = $urandom;
            rsew = 2'($urandom_range(0, 2));
            rvl = 5'($urandom_range(0, 31));
            gen_beats(rwe, rsew, rvl);
            run_op(rwe, rsew, rvl, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
